// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin share of the register-file write port among NUM_SRC sources.
// Optional RF_WB_BYPASS_EN adds two read-address bypass compares against the landing write.
module rf_writeback_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      busy
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         byp_raddr1,
    input  logic [ADDR_W-1:0]         byp_raddr2,
    output logic [1:0]                byp_hit,
    output logic [2*DATA_W-1:0]       byp_data
`endif
);
    localparam int PTR_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [PTR_W-1:0]  ptr_q, ptr_d, gnt_idx;
    logic [PTR_W:0]    cand;
    logic              found, xfer;
    logic [ADDR_W-1:0] sel_addr, rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] sel_data, rf_wdata_q, rf_wdata_d;
    logic              rf_we_q, rf_we_d;

    always_comb begin
        gnt_idx = '0;
        found = 1'b0;
        cand = '0;
        // Walk from the farthest candidate back to ptr so the nearest valid source wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            cand = (cand >= (PTR_W+1)'(NUM_SRC)) ? cand - (PTR_W+1)'(NUM_SRC) : cand;
            if (src_valid[cand[PTR_W-1:0]]) begin
                gnt_idx = cand[PTR_W-1:0];
                found = 1'b1;
            end
        end
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_addr = src_addr[i*ADDR_W +: ADDR_W];
                sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
        xfer = found & ~rst;
        src_ready = '0;
        src_ready[gnt_idx] = xfer;
        ptr_d = !xfer ? ptr_q : (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        rf_we_d = xfer && (sel_addr != '0);
        rf_waddr_d = rf_we_d ? sel_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // A write still pending when reset arrives must not reach the register file.
    assign rf_we    = rf_we_q & ~rst;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = |src_valid;

`ifdef RF_WB_BYPASS_EN
    assign byp_hit[0] = rf_we && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != '0);
    assign byp_hit[1] = rf_we && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != '0);
    assign byp_data   = {byp_hit[1] ? rf_wdata_q : {DATA_W{1'b0}},
                         byp_hit[0] ? rf_wdata_q : {DATA_W{1'b0}}};
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed vectors with hand-computed expectations for rf_writeback_arbiter.
module tb_rf_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  src_valid = '0;
    logic [2:0]  src_ready;
    logic [14:0] src_addr = '0;
    logic [95:0] src_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  byp_raddr1 = '0;
    logic [4:0]  byp_raddr2 = '0;
    logic [1:0]  byp_hit;
    logic [63:0] byp_data;
`endif
    int n_vec = 0;
    int n_bad = 0;

    rf_writeback_arbiter #(.NUM_SRC(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
`ifdef RF_WB_BYPASS_EN
        , .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
        .byp_hit(byp_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        src_valid[i] = v;
        src_addr[i*5 +: 5] = a;
        src_data[i*32 +: 32] = d;
    endtask

    initial begin
        // reset state, ready suppressed while rst is high
        tick();
        tick();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        src_valid = 3'b111;
        #1;
        chk("rst_ready", src_ready, 0);
        chk("rst_busy", busy, 1);
        src_valid = 3'b000;
        rst = 1'b0;
        #1;
        chk("idle_busy", busy, 0);

        // single write from source 0
        set_src(0, 1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("t1_ready", src_ready, 3'b001);
        tick();
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        set_src(0, 0, 5'd0, 32'h0);
        #1;
        chk("t1_ready_off", src_ready, 0);
        tick();
        chk("t1_we_off", rf_we, 0);
        chk("t1_hold_addr", rf_waddr, 5);
        chk("t1_hold_data", rf_wdata, 32'hDEADBEEF);

        // all three continuously valid from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, 1, 5'(i + 1), 32'h100 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("t2_ready%0d", c), src_ready, 64'(3'b001 << (c % 3)));
            tick();
            chk($sformatf("t2_we%0d", c), rf_we, 1);
            chk($sformatf("t2_waddr%0d", c), rf_waddr, 64'((c % 3) + 1));
            chk($sformatf("t2_wdata%0d", c), rf_wdata, 64'(32'h100 + (c % 3)));
        end
        src_valid = '0;
        tick();
        chk("t2_we_off", rf_we, 0);

        // write to $zero is accepted but dropped; ptr moves to 2
        set_src(1, 1, 5'd0, 32'h1234);
        #1;
        chk("t3_ready", src_ready, 3'b010);
        tick();
        chk("t3_we", rf_we, 0);
        chk("t3_hold_addr", rf_waddr, 3);
        set_src(1, 0, 5'd0, 32'h0);

        // ptr=2: source 2 first, then 0, then 2 again
        set_src(0, 1, 5'd10, 32'hA0);
        set_src(2, 1, 5'd12, 32'hC0);
        #1;
        chk("t4_ready_a", src_ready, 3'b100);
        tick();
        chk("t4_waddr_a", rf_waddr, 12);
        chk("t4_ready_b", src_ready, 3'b001);
        tick();
        chk("t4_waddr_b", rf_waddr, 10);
        chk("t4_wdata_b", rf_wdata, 32'hA0);
        chk("t4_ready_c", src_ready, 3'b100);
        tick();
        chk("t4_waddr_c", rf_waddr, 12);
        chk("t4_we_c", rf_we, 1);
        src_valid = '0;
        tick();

        // reset right after a grant of addr 7 kills the write and resets ptr
        set_src(0, 1, 5'd7, 32'h77);
        #1;
        chk("t5_ready", src_ready, 3'b001);
        tick();
        src_valid = '0;
        rst = 1'b1;
        #1;
        chk("t5_we_in_rst", rf_we, 0);
        tick();
        chk("t5_we", rf_we, 0);
        chk("t5_waddr", rf_waddr, 0);
        chk("t5_wdata", rf_wdata, 0);
        rst = 1'b0;
        set_src(0, 1, 5'd7, 32'h77);
        set_src(1, 1, 5'd8, 32'h88);
        #1;
        chk("t5_ptr0", src_ready, 3'b001);
        tick();
        chk("t5_waddr0", rf_waddr, 7);
        chk("t5_ready1", src_ready, 3'b010);
        tick();
        chk("t5_waddr1", rf_waddr, 8);
        chk("t5_wdata1", rf_wdata, 32'h88);
        src_valid = '0;
        tick();

`ifdef RF_WB_BYPASS_EN
        set_src(2, 1, 5'd9, 32'hA5A5A5A5);
        byp_raddr1 = 5'd9;
        byp_raddr2 = 5'd4;
        tick();
        set_src(2, 0, 5'd0, 32'h0);
        #1;
        chk("t6_hit", byp_hit, 2'b01);
        chk("t6_data0", byp_data[31:0], 32'hA5A5A5A5);
        chk("t6_data1", byp_data[63:32], 0);
        byp_raddr1 = 5'd0;
        #1;
        chk("t6_hit_zero", byp_hit, 2'b00);
        tick();
        byp_raddr1 = 5'd9;
        #1;
        chk("t6_hit_idle", byp_hit, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
